// File: rtl/inst_fetch_queue.sv
// In-order instruction fetch queue between a variable-latency imem port and decode.
// Optional macro HALT_STOP_EN: stop issuing fetches once a halt-opcode word is written.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h2000,
  parameter logic [4:0]  HALT_OPC = 5'h0f
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        id_valid,
  output logic [63:0] id_pc,
  output logic [31:0] id_instr,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        fetch_halted
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

`ifdef HALT_STOP_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic [63:0]     pc_q    [DEPTH];
  logic [31:0]     instr_q [DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [AW-1:0]   head_ptr, tail_ptr, fill_ptr;
  logic [CW-1:0]   count, pend_cnt, drop_cnt;
  logic [63:0]     fetch_pc;
  logic            halted;

  logic accept, deq, fill, drop;

  // Handshakes: a transfer happens on a cycle where valid && ready are both high;
  // a producer holds valid and its payload stable until that cycle.
  assign imem_req_valid = !reset && ((count + drop_cnt) < DEPTH_C) && !redirect_valid && !halted;
  assign imem_req_addr  = reset ? 64'h0 : fetch_pc;
  assign id_valid       = !reset && (count != '0) && filled_q[head_ptr];
  assign id_pc          = id_valid ? pc_q[head_ptr] : 64'h0;
  assign id_instr       = id_valid ? instr_q[head_ptr] : 32'h0;
  assign fetch_halted   = halted;

  assign accept = imem_req_valid && imem_req_ready;
  assign deq    = id_valid && id_ready && !redirect_valid;
  assign fill   = imem_resp_valid && (drop_cnt == '0) && (pend_cnt != '0) && !redirect_valid;
  assign drop   = imem_resp_valid && (drop_cnt != '0);

  // Payload storage carries no reset; the filled flags decide what is visible.
  always_ff @(posedge clk) begin
    if (accept) pc_q[tail_ptr] <= fetch_pc;
    if (fill)   instr_q[fill_ptr] <= imem_resp_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      head_ptr <= '0;
      tail_ptr <= '0;
      fill_ptr <= '0;
      count    <= '0;
      pend_cnt <= '0;
      drop_cnt <= '0;
      filled_q <= '0;
      halted   <= 1'b0;
    end else if (redirect_valid) begin
      // Every unfilled reservation becomes a response to throw away; a response
      // arriving this same cycle already retires one of them.
      fetch_pc <= redirect_pc;
      head_ptr <= '0;
      tail_ptr <= '0;
      fill_ptr <= '0;
      count    <= '0;
      pend_cnt <= '0;
      filled_q <= '0;
      halted   <= 1'b0;
      drop_cnt <= drop_cnt + pend_cnt - CW'(imem_resp_valid);
    end else begin
      if (accept) begin
        filled_q[tail_ptr] <= 1'b0;
        tail_ptr <= tail_ptr + AW'(1);
        fetch_pc <= fetch_pc + 64'd4;
      end
      if (fill) begin
        filled_q[fill_ptr] <= 1'b1;
        fill_ptr <= fill_ptr + AW'(1);
        if (HALT_EN && (imem_resp_data[31:27] == HALT_OPC)) halted <= 1'b1;
      end
      if (drop) drop_cnt <= drop_cnt - CW'(1);
      if (deq)  head_ptr <= head_ptr + AW'(1);
      count    <= count + CW'(accept) - CW'(deq);
      pend_cnt <= pend_cnt + CW'(accept) - CW'(fill);
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: in-order memory model, queue-level reference model,
// per-cycle compare on the falling edge plus literal checks per scenario.
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [31:0] id_instr;
  logic        id_ready;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        fetch_halted;

  inst_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr), .id_ready(id_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fetch_halted(fetch_halted)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  typedef struct { logic [63:0] addr; int due; } mreq_t;
  mreq_t       mem_q[$];
  int          cyc = 0;
  int          mem_lat = 1;
  logic [63:0] halt_addr = 64'hffff_ffff_ffff_fff0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == halt_addr) return 32'h7800_0000;
    return {8'h10, a[23:0]};
  endfunction

  logic        s_req, s_idv, s_halt;
  logic [63:0] s_addr, s_idpc;
  logic [31:0] s_instr;
  int          n_acc;

  // One cycle: drive the response, sample at the falling edge, advance past the rising edge.
  task automatic step();
    bit rv;
    rv = !reset && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_resp_valid = rv;
    imem_resp_data  = rv ? mem_word(mem_q[0].addr) : 32'h0;
    @(negedge clk);
    s_req = imem_req_valid; s_addr = imem_req_addr; s_idv = id_valid;
    s_idpc = id_pc; s_instr = id_instr; s_halt = fetch_halted;
    if (reset) mem_q.delete();
    else begin
      if (rv) void'(mem_q.pop_front());
      if (imem_req_valid && imem_req_ready) begin
        mem_q.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
        n_acc++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect_valid = 1'b0; id_ready = 1'b0; imem_req_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // ---------------- reference model + compare ----------------
  logic [63:0] m_pc = 64'h2000;
  logic [63:0] pend_q[$];
  logic [63:0] rpc_q[$];
  logic [31:0] rin_q[$];
  int          m_drop = 0;
  bit          m_halt = 1'b0;

  always @(negedge clk) begin
    bit e_req, e_idv;
    logic [63:0] p;
    if (reset) begin
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_id_valid", id_valid, 0);
      chk("rst_id_pc", id_pc, 0);
      chk("rst_halted", fetch_halted, 0);
      m_pc = 64'h2000; m_drop = 0; m_halt = 1'b0;
      pend_q.delete(); rpc_q.delete(); rin_q.delete();
    end else begin
      e_req = ((pend_q.size() + rpc_q.size() + m_drop) < DEPTH) && !redirect_valid && !m_halt;
      e_idv = rpc_q.size() != 0;
      chk("req_valid", imem_req_valid, e_req);
      if (e_req) chk("req_addr", imem_req_addr, m_pc);
      chk("id_valid", id_valid, e_idv);
      chk("id_pc", id_pc, e_idv ? rpc_q[0] : 64'h0);
      chk("id_instr", id_instr, e_idv ? rin_q[0] : 32'h0);
      chk("halted", fetch_halted, m_halt);
      if (imem_resp_valid) chk("resp_has_req", (pend_q.size() + m_drop) != 0, 1);
      if (redirect_valid) begin
        m_drop = m_drop + pend_q.size() - (imem_resp_valid ? 1 : 0);
        pend_q.delete(); rpc_q.delete(); rin_q.delete();
        m_pc = redirect_pc; m_halt = 1'b0;
      end else begin
        if (e_idv && id_ready) begin
          void'(rpc_q.pop_front());
          void'(rin_q.pop_front());
        end
        if (imem_resp_valid) begin
          if (m_drop > 0) m_drop--;
          else if (pend_q.size() > 0) begin
            p = pend_q.pop_front();
            rpc_q.push_back(p);
            rin_q.push_back(imem_resp_data);
`ifdef HALT_STOP_EN
            if (imem_resp_data[31:27] == 5'h0f) m_halt = 1'b1;
`endif
          end
        end
        if (e_req && imem_req_ready) begin
          pend_q.push_back(m_pc);
          m_pc = m_pc + 64'd4;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] first_pc;
    bit          seen;
    reset = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // reset state
    step();
    chk("reset_req", s_req, 0); chk("reset_idv", s_idv, 0);
    chk("reset_idpc", s_idpc, 0); chk("reset_halt", s_halt, 0);

    // 1: streaming at one instruction per cycle
    do_reset(); mem_lat = 1; imem_req_ready = 1'b1; id_ready = 1'b1;
    step(); chk("t1_req0", s_req, 1); chk("t1_addr0", s_addr, 64'h2000); chk("t1_idv0", s_idv, 0);
    step(); chk("t1_addr1", s_addr, 64'h2004); chk("t1_idv1", s_idv, 0);
    step(); chk("t1_idv2", s_idv, 1); chk("t1_idpc2", s_idpc, 64'h2000); chk("t1_addr2", s_addr, 64'h2008);
    repeat (5) step();
    chk("t1_idv7", s_idv, 1); chk("t1_idpc7", s_idpc, 64'h2014);

    // 2: back-pressure fills the queue, one dequeue frees one slot
    do_reset(); mem_lat = 1; imem_req_ready = 1'b1; id_ready = 1'b0; n_acc = 0;
    repeat (6) step();
    chk("t2_accepts", n_acc, 4); chk("t2_full_req", s_req, 0);
    id_ready = 1'b1; step();
    chk("t2_deq_idv", s_idv, 1); chk("t2_deq_pc", s_idpc, 64'h2000); chk("t2_deq_req", s_req, 0);
    id_ready = 1'b0; step();
    chk("t2_resume_req", s_req, 1); chk("t2_resume_addr", s_addr, 64'h2010);

    // 3: redirect with two requests in flight
    do_reset(); mem_lat = 3; imem_req_ready = 1'b1; id_ready = 1'b1;
    step(); step();
    redirect_valid = 1'b1; redirect_pc = 64'h3000; step();
    chk("t3_redir_req", s_req, 0);
    redirect_valid = 1'b0; step();
    chk("t3_req", s_req, 1); chk("t3_addr", s_addr, 64'h3000);
    seen = 1'b0; first_pc = '0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (s_idv && !seen) begin seen = 1'b1; first_pc = s_idpc; end
    end
    chk("t3_seen", seen, 1); chk("t3_first_pc", first_pc, 64'h3000);

    // 4: redirect coinciding with a response and a ready head
    do_reset(); mem_lat = 2; imem_req_ready = 1'b1; id_ready = 1'b1;
    repeat (3) step();
    redirect_valid = 1'b1; redirect_pc = 64'h4000; step();
    chk("t4_redir_idv", s_idv, 1); chk("t4_redir_idpc", s_idpc, 64'h2000);
    redirect_valid = 1'b0; step();
    chk("t4_empty", s_idv, 0); chk("t4_req", s_req, 1); chk("t4_addr", s_addr, 64'h4000);
    seen = 1'b0; first_pc = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (s_idv && !seen) begin seen = 1'b1; first_pc = s_idpc; end
    end
    chk("t4_seen", seen, 1); chk("t4_first_pc", first_pc, 64'h4000);

    // 5: asynchronous reset with entries queued
    do_reset(); mem_lat = 1; imem_req_ready = 1'b1; id_ready = 1'b0;
    repeat (4) step();
    chk("t5_pre_idv", s_idv, 1);
    reset = 1'b1; #1;
    chk("t5_imm_idv", id_valid, 0); chk("t5_imm_req", imem_req_valid, 0);
    step(); step();
    reset = 1'b0; step();
    chk("t5_restart_req", s_req, 1); chk("t5_restart_addr", s_addr, 64'h2000);

    // 6: halt word at 0x2008
    do_reset(); mem_lat = 1; imem_req_ready = 1'b1; id_ready = 1'b1; halt_addr = 64'h2008;
    repeat (4) step();
    chk("t6_req3", s_req, 1); chk("t6_addr3", s_addr, 64'h200c);
    step();
    chk("t6_idpc", s_idpc, 64'h2008); chk("t6_instr", s_instr, 32'h7800_0000);
`ifdef HALT_STOP_EN
    chk("t6_halted", s_halt, 1); chk("t6_halt_req", s_req, 0);
`else
    chk("t6_halted", s_halt, 0); chk("t6_cont_req", s_req, 1); chk("t6_cont_addr", s_addr, 64'h2010);
`endif
    step();
    redirect_valid = 1'b1; redirect_pc = 64'h2100; step();
    redirect_valid = 1'b0; step();
    chk("t6_resume_req", s_req, 1); chk("t6_resume_addr", s_addr, 64'h2100); chk("t6_cleared", s_halt, 0);
    halt_addr = 64'hffff_ffff_ffff_fff0;
    repeat (6) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
